// File: rtl/rdback_pack_ctrl_if.sv
// Readback stream in (16-bit words) and packed host line out, plus flush and status.
// Pure wiring bundle: no storage, no added latency.
// Backpressure: in_ready gates words into the packer; line_ready releases a held line.
interface rdback_pack_ctrl_if;
    logic [15:0]  in;
    logic         in_valid;
    logic         in_ready;
    logic         flush;
    logic [511:0] line_data;
    logic [5:0]   line_words;
    logic         line_valid;
    logic         line_ready;
    logic         flush_done;
    logic [31:0]  lines_sent;

    // Capture/host side: drives words, flush and line_ready.
    modport master (
        output in, in_valid, flush, line_ready,
        input  in_ready, line_data, line_words, line_valid, flush_done, lines_sent
    );

    // Packer side.
    modport slave (
        input  in, in_valid, flush, line_ready,
        output in_ready, line_data, line_words, line_valid, flush_done, lines_sent
    );
endinterface

// File: rtl/rdback_pack_ctrl.sv
// Packs 16-bit readback words into 512-bit host lines (newest word in [15:0]); optional idle-timeout flush under RDBACK_TIMEOUT_EN.
// Latency: line_valid one cycle after the 32nd accept or a flush; flush_done one cycle after the flushed line's handoff.
// Backpressure: in_ready drops while a line is held; the line stays stable until line_ready, with no accept on the handoff cycle.
module rdback_pack_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    rdback_pack_ctrl_if.slave   rb
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t         r_state, w_state_nxt;
    logic [511:0]   r_pack, w_pack_nxt;
    logic [5:0]     r_count, w_count_nxt;
    logic           r_flush_tag, w_flush_tag_nxt;
    logic           r_flush_done, w_flush_done_nxt;
    logic [31:0]    r_lines_sent, w_lines_sent_nxt;
    logic           w_in_ready;
    logic           w_accept;
    logic           w_timeout;

    // Elaboration guard: the idle counter is 16 bits wide.
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("rdback_pack_ctrl: TIMEOUT_CYCLES must be in 2..65535");
    end

    assign w_in_ready = (r_state != ST_HOLD) && !rst;
    assign w_accept   = rb.in_valid && w_in_ready;

`ifdef RDBACK_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] r_idle_cnt;

    // Idle counter: held at zero outside FILL so it restarts on FILL entry, cleared by every accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idle_cnt <= '0;
        end else if (r_state != ST_FILL || w_accept) begin
            r_idle_cnt <= '0;
        end else if (r_idle_cnt != TIMEOUT_LAST) begin
            r_idle_cnt <= r_idle_cnt + 16'd1;
        end
    end

    assign w_timeout = (r_state == ST_FILL) && !w_accept && (r_idle_cnt == TIMEOUT_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    // State and datapath registers; reset discards any partial line and pending flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_pack       <= '0;
            r_count      <= '0;
            r_flush_tag  <= 1'b0;
            r_flush_done <= 1'b0;
            r_lines_sent <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pack       <= w_pack_nxt;
            r_count      <= w_count_nxt;
            r_flush_tag  <= w_flush_tag_nxt;
            r_flush_done <= w_flush_done_nxt;
            r_lines_sent <= w_lines_sent_nxt;
        end
    end

    // Next state: an accepted word is always packed first, then flush/complete/timeout decide the state.
    always_comb begin
        w_state_nxt      = r_state;
        w_pack_nxt       = r_pack;
        w_count_nxt      = r_count;
        w_flush_tag_nxt  = r_flush_tag;
        w_flush_done_nxt = 1'b0;
        w_lines_sent_nxt = r_lines_sent;

        if (w_accept) begin
            w_pack_nxt  = {r_pack[495:0], rb.in};
            w_count_nxt = r_count + 6'd1;
        end

        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    // A flush alongside the first word closes a one-word line.
                    w_state_nxt     = rb.flush ? ST_HOLD : ST_FILL;
                    w_flush_tag_nxt = rb.flush;
                end else if (rb.flush) begin
                    // Nothing buffered: the request is already satisfied.
                    w_flush_done_nxt = 1'b1;
                end
            end
            ST_FILL: begin
                if (w_accept && r_count == 6'd31) begin
                    w_state_nxt     = ST_HOLD;
                    w_flush_tag_nxt = rb.flush;
                end else if (rb.flush) begin
                    w_state_nxt     = ST_HOLD;
                    w_flush_tag_nxt = 1'b1;
                end else if (w_timeout) begin
                    w_state_nxt     = ST_HOLD;
                    w_flush_tag_nxt = 1'b0;
                end
            end
            ST_HOLD: begin
                if (rb.line_ready) begin
                    w_state_nxt      = ST_IDLE;
                    w_pack_nxt       = '0;
                    w_count_nxt      = '0;
                    w_lines_sent_nxt = r_lines_sent + 32'd1;
                    // A flush arriving while held is satisfied by the held line.
                    w_flush_done_nxt = r_flush_tag || rb.flush;
                    w_flush_tag_nxt  = 1'b0;
                end else if (rb.flush) begin
                    w_flush_tag_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign rb.in_ready   = w_in_ready;
    assign rb.line_valid = (r_state == ST_HOLD);
    assign rb.line_data  = r_pack;
    assign rb.line_words = r_count;
    assign rb.flush_done = r_flush_done;
    assign rb.lines_sent = r_lines_sent;

endmodule
